// File: rtl/rob_pkg.sv
// Shared types for the reorder buffer: instruction class encoding, default sizing and entry layout.
package rob_pkg;

  localparam int unsigned DEFAULT_RENAME_W = 4;
  localparam int unsigned DEFAULT_DEPTH    = 16;

  typedef enum logic [1:0] {
    ROB_NORMAL = 2'd0,
    ROB_BRANCH = 2'd1,
    ROB_JALR   = 2'd2,
    ROB_RSVD   = 2'd3
  } rob_type_e;

  typedef struct packed {
    logic        busy;
    logic        ready;
    rob_type_e   rtype;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic        pred;
    logic [31:0] alt_pc;
    logic [31:0] value;
  } rob_entry_t;

endpackage

// File: rtl/rob_commit.sv
// Reorder buffer with in-order commit and branch-mispredict flush.
// Optional ROB_COMMIT_COUNT_EN adds a free-running retired-instruction counter output.
module rob_commit
  import rob_pkg::*;
#(
  parameter int unsigned RENAME_W = DEFAULT_RENAME_W,
  parameter int unsigned DEPTH    = DEFAULT_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                issue_valid,
  input  logic [1:0]          issue_type,
  input  logic [4:0]          issue_dest,
  input  logic [31:0]         issue_pc,
  input  logic                issue_pred_jump,
  input  logic [31:0]         issue_alt_pc,
  output logic [RENAME_W-1:0] issue_rename,
  output logic                rob_full,
  input  logic                alu_wb_valid,
  input  logic [RENAME_W-1:0] alu_wb_rename,
  input  logic [31:0]         alu_wb_value,
  input  logic                lsb_wb_valid,
  input  logic [RENAME_W-1:0] lsb_wb_rename,
  input  logic [31:0]         lsb_wb_value,
  input  logic [RENAME_W-1:0] query_rename1,
  input  logic [RENAME_W-1:0] query_rename2,
  output logic                query_ready1,
  output logic                query_ready2,
  output logic [31:0]         query_value1,
  output logic [31:0]         query_value2,
  output logic                commit_flag,
  output logic [31:0]         commit_value,
  output logic [RENAME_W-1:0] commit_rename,
  output logic [4:0]          commit_dest,
  output logic                commit_is_branch,
  output logic                commit_is_jalr,
  output logic [31:0]         jalr_next_pc,
  output logic                cdb_flush,
  output logic [31:0]         flush_pc
`ifdef ROB_COMMIT_COUNT_EN
  ,
  output logic [31:0]         commit_count
`endif
);

  localparam logic [RENAME_W:0] FullCount = DEPTH[RENAME_W:0];

  rob_entry_t          entries_q [DEPTH];
  logic [RENAME_W-1:0] head_q, tail_q;
  logic [RENAME_W:0]   count_q, count_d;
  logic                flush_pending_q;
  logic [31:0]         flush_target_q;

  rob_entry_t head_e;
  logic       issue_fire, commit_fire, flush_fire, mispredict;

  assign head_e       = entries_q[head_q];
  assign rob_full     = (count_q == FullCount);
  assign issue_rename = tail_q;

  // Nothing new enters or leaves while a flush is waiting to clear the buffer.
  assign issue_fire  = rdy && issue_valid && !rob_full && !flush_pending_q;
  assign commit_fire = rdy && head_e.busy && head_e.ready && !flush_pending_q;
  assign flush_fire  = rdy && flush_pending_q;
  assign mispredict  = commit_fire && (head_e.rtype == ROB_BRANCH) &&
                       (head_e.value[0] != head_e.pred);

  assign query_ready1 = entries_q[query_rename1].busy && entries_q[query_rename1].ready;
  assign query_ready2 = entries_q[query_rename2].busy && entries_q[query_rename2].ready;
  assign query_value1 = entries_q[query_rename1].value;
  assign query_value2 = entries_q[query_rename2].value;

  always_comb begin
    count_d = count_q;
    if (issue_fire && !commit_fire) begin
      count_d = count_q + (RENAME_W + 1)'(1);
    end else if (!issue_fire && commit_fire) begin
      count_d = count_q - (RENAME_W + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_q[i] <= '0;
      end
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      flush_pending_q  <= 1'b0;
      flush_target_q   <= '0;
      commit_flag      <= 1'b0;
      commit_value     <= '0;
      commit_rename    <= '0;
      commit_dest      <= '0;
      commit_is_branch <= 1'b0;
      commit_is_jalr   <= 1'b0;
      jalr_next_pc     <= '0;
      cdb_flush        <= 1'b0;
      flush_pc         <= '0;
    end else begin
      commit_flag <= commit_fire;
      cdb_flush   <= flush_fire;
      if (flush_fire) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          entries_q[i].busy <= 1'b0;
        end
        head_q          <= '0;
        tail_q          <= '0;
        count_q         <= '0;
        flush_pending_q <= 1'b0;
        flush_pc        <= flush_target_q;
      end else if (rdy) begin
        // LSB is applied last so it wins a same-tag collision.
        if (alu_wb_valid && entries_q[alu_wb_rename].busy) begin
          entries_q[alu_wb_rename].value <= alu_wb_value;
          entries_q[alu_wb_rename].ready <= 1'b1;
        end
        if (lsb_wb_valid && entries_q[lsb_wb_rename].busy) begin
          entries_q[lsb_wb_rename].value <= lsb_wb_value;
          entries_q[lsb_wb_rename].ready <= 1'b1;
        end
        if (issue_fire) begin
          entries_q[tail_q] <= '{busy:   1'b1,
                                 ready:  1'b0,
                                 rtype:  rob_type_e'(issue_type),
                                 dest:   issue_dest,
                                 pc:     issue_pc,
                                 pred:   issue_pred_jump,
                                 alt_pc: issue_alt_pc,
                                 value:  32'd0};
          tail_q <= tail_q + RENAME_W'(1);
        end
        if (commit_fire) begin
          entries_q[head_q].busy <= 1'b0;
          head_q                 <= head_q + RENAME_W'(1);
          commit_value           <= head_e.value;
          commit_rename          <= head_q;
          commit_dest            <= head_e.dest;
          commit_is_branch       <= (head_e.rtype == ROB_BRANCH);
          commit_is_jalr         <= (head_e.rtype == ROB_JALR);
          jalr_next_pc           <= head_e.pc + 32'd4;
        end
        if (mispredict) begin
          flush_pending_q <= 1'b1;
          flush_target_q  <= head_e.alt_pc;
        end
        count_q <= count_d;
      end
    end
  end

`ifdef ROB_COMMIT_COUNT_EN
  // Counts retirements only; a flush does not touch it.
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_count <= '0;
    end else if (commit_flag) begin
      commit_count <= commit_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rob_commit.sv
// Scoreboard bench for rob_commit: expected commits queued at issue, checked when commit_flag fires.
module tb_rob_commit;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        issue_valid, issue_pred_jump;
  logic [1:0]  issue_type;
  logic [4:0]  issue_dest;
  logic [31:0] issue_pc, issue_alt_pc;
  logic [3:0]  issue_rename;
  logic        rob_full;
  logic        alu_wb_valid, lsb_wb_valid;
  logic [3:0]  alu_wb_rename, lsb_wb_rename;
  logic [31:0] alu_wb_value, lsb_wb_value;
  logic [3:0]  query_rename1, query_rename2;
  logic        query_ready1, query_ready2;
  logic [31:0] query_value1, query_value2;
  logic        commit_flag, commit_is_branch, commit_is_jalr, cdb_flush;
  logic [31:0] commit_value, jalr_next_pc, flush_pc;
  logic [3:0]  commit_rename;
  logic [4:0]  commit_dest;
`ifdef ROB_COMMIT_COUNT_EN
  logic [31:0] commit_count;
`endif

  rob_commit dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_dest(issue_dest),
    .issue_pc(issue_pc), .issue_pred_jump(issue_pred_jump), .issue_alt_pc(issue_alt_pc),
    .issue_rename(issue_rename), .rob_full(rob_full),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rename(alu_wb_rename), .alu_wb_value(alu_wb_value),
    .lsb_wb_valid(lsb_wb_valid), .lsb_wb_rename(lsb_wb_rename), .lsb_wb_value(lsb_wb_value),
    .query_rename1(query_rename1), .query_rename2(query_rename2),
    .query_ready1(query_ready1), .query_ready2(query_ready2),
    .query_value1(query_value1), .query_value2(query_value2),
    .commit_flag(commit_flag), .commit_value(commit_value), .commit_rename(commit_rename),
    .commit_dest(commit_dest), .commit_is_branch(commit_is_branch),
    .commit_is_jalr(commit_is_jalr), .jalr_next_pc(jalr_next_pc),
    .cdb_flush(cdb_flush), .flush_pc(flush_pc)
`ifdef ROB_COMMIT_COUNT_EN
    , .commit_count(commit_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  tag;
    logic [4:0]  dest;
    logic        br;
    logic        jr;
    logic [31:0] npc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] wb_val [16];
  logic [3:0]  exp_tail;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          flush_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && commit_flag) begin
      if (sb.size() == 0) begin
        check_eq("spurious_commit", 32'(commit_flag), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("commit_rename", 32'(commit_rename), 32'(mon_e.tag));
        check_eq("commit_dest", 32'(commit_dest), 32'(mon_e.dest));
        check_eq("commit_value", commit_value, wb_val[mon_e.tag]);
        check_eq("commit_is_branch", 32'(commit_is_branch), 32'(mon_e.br));
        check_eq("commit_is_jalr", 32'(commit_is_jalr), 32'(mon_e.jr));
        check_eq("jalr_next_pc", jalr_next_pc, mon_e.npc);
      end
    end
    if (!rst && cdb_flush) flush_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rdy = 1'b1; issue_valid = 1'b0; issue_type = 2'd0; issue_dest = 5'd0;
    issue_pc = 32'd0; issue_pred_jump = 1'b0; issue_alt_pc = 32'd0;
    alu_wb_valid = 1'b0; alu_wb_rename = 4'd0; alu_wb_value = 32'd0;
    lsb_wb_valid = 1'b0; lsb_wb_rename = 4'd0; lsb_wb_value = 32'd0;
    query_rename1 = 4'd0; query_rename2 = 4'd0;
    tick(); tick();
    rst = 1'b0;
    sb.delete();
    exp_tail = 4'd0;
    @(negedge clk);
    check_eq("rst_commit_flag", 32'(commit_flag), 32'd0);
    check_eq("rst_cdb_flush", 32'(cdb_flush), 32'd0);
    check_eq("rst_rob_full", 32'(rob_full), 32'd0);
    check_eq("rst_issue_rename", 32'(issue_rename), 32'd0);
    check_eq("rst_flush_pc", flush_pc, 32'd0);
    check_eq("rst_query_ready", 32'(query_ready1), 32'd0);
    tick();
  endtask

  task automatic issue_op(input logic [1:0] t, input logic [4:0] d, input logic [31:0] pc,
                          input logic pr, input logic [31:0] alt, input bit track);
    issue_valid = 1'b1; issue_type = t; issue_dest = d; issue_pc = pc;
    issue_pred_jump = pr; issue_alt_pc = alt;
    check_eq("issue_rename", 32'(issue_rename), 32'(exp_tail));
    if (track) sb.push_back('{tag: exp_tail, dest: d, br: (t == 2'd1), jr: (t == 2'd2),
                              npc: pc + 32'd4});
    exp_tail = exp_tail + 4'd1;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic wb(input bit use_lsb, input logic [3:0] tag, input logic [31:0] val);
    wb_val[tag] = val;
    if (use_lsb) begin
      lsb_wb_valid = 1'b1; lsb_wb_rename = tag; lsb_wb_value = val;
    end else begin
      alu_wb_valid = 1'b1; alu_wb_rename = tag; alu_wb_value = val;
    end
    tick();
    alu_wb_valid = 1'b0; lsb_wb_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check_eq("drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] t0, t1;
    int base, n;

    // In-order retirement with out-of-order writeback, plus operand queries.
    do_reset();
    issue_op(2'd0, 5'd1, 32'h1000, 1'b0, 32'd0, 1'b1);
    issue_op(2'd0, 5'd2, 32'h1004, 1'b0, 32'd0, 1'b1);
    issue_op(2'd0, 5'd3, 32'h1008, 1'b0, 32'd0, 1'b1);
    wb(1'b0, 4'd2, 32'h22);
    tick(); tick();
    query_rename1 = 4'd2; query_rename2 = 4'd1;
    @(negedge clk);
    check_eq("query_ready_done", 32'(query_ready1), 32'd1);
    check_eq("query_value_done", query_value1, 32'h22);
    check_eq("query_ready_pending", 32'(query_ready2), 32'd0);
    check_eq("no_early_commit", 32'(sb.size()), 32'd3);
    tick();
    wb(1'b1, 4'd0, 32'h11);
    wb(1'b0, 4'd1, 32'h33);
    wait_drain();

    // Full buffer, rejected issues, wrap of the tail, LSB priority on a shared tag.
    do_reset();
    for (int i = 0; i < 16; i++) issue_op(2'd0, 5'(i + 1), 32'h2000 + 32'(4 * i), 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    check_eq("full_after_16", 32'(rob_full), 32'd1);
    tick();
    issue_valid = 1'b1; issue_dest = 5'd31;
    tick();
    issue_valid = 1'b0;
    wb(1'b0, 4'd0, 32'hA0);
    issue_valid = 1'b1; issue_dest = 5'd30;
    @(negedge clk);
    check_eq("full_in_commit_cycle", 32'(rob_full), 32'd1);
    tick();
    issue_valid = 1'b0;
    issue_op(2'd0, 5'd5, 32'h3000, 1'b0, 32'd0, 1'b1);
    for (int i = 1; i < 16; i++) begin
      if (i == 7) begin
        wb_val[7] = 32'h77;
        alu_wb_valid = 1'b1; alu_wb_rename = 4'd7; alu_wb_value = 32'hDEAD;
        lsb_wb_valid = 1'b1; lsb_wb_rename = 4'd7; lsb_wb_value = 32'h77;
        tick();
        alu_wb_valid = 1'b0; lsb_wb_valid = 1'b0;
      end else begin
        wb(1'(i % 2), 4'(i), 32'h100 + 32'(i));
      end
    end
    wb(1'b1, 4'd0, 32'hB0);
    wait_drain();
    @(negedge clk);
    check_eq("not_full_after_drain", 32'(rob_full), 32'd0);
    check_eq("tail_after_wrap", 32'(issue_rename), 32'(exp_tail));
    tick();

    // Mispredicted branch: commit, then flush with redirect; younger ops never retire.
    do_reset();
    base = flush_cnt;
    issue_op(2'd1, 5'd0, 32'h1000, 1'b1, 32'h1040, 1'b1);
    issue_op(2'd0, 5'd4, 32'h1004, 1'b0, 32'd0, 1'b0);
    issue_op(2'd0, 5'd5, 32'h1008, 1'b0, 32'd0, 1'b0);
    wb(1'b0, 4'd1, 32'h44);
    wb(1'b1, 4'd2, 32'h55);
    wb(1'b0, 4'd0, 32'h0);
    @(negedge clk);
    check_eq("flush_before_commit", 32'(cdb_flush), 32'd0);
    tick();
    issue_valid = 1'b1; issue_type = 2'd0; issue_dest = 5'd9;
    @(negedge clk);
    check_eq("flush_not_with_commit", 32'(cdb_flush), 32'd0);
    tick();
    issue_valid = 1'b0;
    exp_tail = 4'd0;
    @(negedge clk);
    check_eq("cdb_flush", 32'(cdb_flush), 32'd1);
    check_eq("flush_pc", flush_pc, 32'h1040);
    check_eq("flush_not_full", 32'(rob_full), 32'd0);
    check_eq("flush_tail_zero", 32'(issue_rename), 32'd0);
    tick();
    @(negedge clk);
    check_eq("flush_pulse_ends", 32'(cdb_flush), 32'd0);
    query_rename1 = 4'd1;
    #1;
    check_eq("flushed_entry_not_ready", 32'(query_ready1), 32'd0);
    repeat (8) tick();
    check_eq("flush_count_1", 32'(flush_cnt - base), 32'd1);

    // Correctly predicted branch and jalr retire without flushing.
    t0 = exp_tail;
    issue_op(2'd1, 5'd0, 32'h1100, 1'b0, 32'h2000, 1'b1);
    wb(1'b0, t0, 32'h0);
    wait_drain();
    t0 = exp_tail;
    issue_op(2'd2, 5'd1, 32'h100, 1'b0, 32'd0, 1'b1);
    wb(1'b1, t0, 32'h200);
    wait_drain();
    repeat (3) tick();
    check_eq("no_flush_good_pred_jalr", 32'(flush_cnt - base), 32'd1);

    // rdy low stalls retirement of a ready head.
    t0 = exp_tail;
    issue_op(2'd0, 5'd6, 32'h4000, 1'b0, 32'd0, 1'b1);
    t1 = exp_tail;
    issue_op(2'd0, 5'd7, 32'h4004, 1'b0, 32'd0, 1'b1);
    wb(1'b0, t0, 32'h55);
    rdy = 1'b0;
    query_rename1 = t0; query_rename2 = t1;
    repeat (4) begin
      @(negedge clk);
      check_eq("rdy_low_no_commit", 32'(commit_flag), 32'd0);
      tick();
    end
    check_eq("rdy_low_query_ready", 32'(query_ready1), 32'd1);
    check_eq("rdy_low_query_value", query_value1, 32'h55);
    check_eq("rdy_low_query_pending", 32'(query_ready2), 32'd0);
    rdy = 1'b1;
    wb(1'b1, t1, 32'h66);
    wait_drain();

    // Five retirements, then a flush; the retire counter keeps its value.
    do_reset();
    base = flush_cnt;
    for (int i = 0; i < 4; i++) issue_op(2'd0, 5'(10 + i), 32'h5000 + 32'(4 * i), 1'b0, 32'd0, 1'b1);
    issue_op(2'd1, 5'd0, 32'h5010, 1'b1, 32'h6000, 1'b1);
    issue_op(2'd0, 5'd20, 32'h5014, 1'b0, 32'd0, 1'b0);
    wb(1'b0, 4'd5, 32'h99);
    for (int i = 0; i < 4; i++) wb(1'(i % 2), 4'(i), 32'h500 + 32'(i));
    wb(1'b0, 4'd4, 32'h0);
    n = 0;
    while (flush_cnt == base && n < 50) begin
      tick();
      n++;
    end
    check_eq("flush_seen", 32'(flush_cnt - base), 32'd1);
    check_eq("flush_pc_2", flush_pc, 32'h6000);
    wait_drain();
    repeat (3) tick();
`ifdef ROB_COMMIT_COUNT_EN
    check_eq("commit_count", commit_count, 32'd5);
`endif
    check_eq("flush_count_2", 32'(flush_cnt - base), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- Reorder buffer: allocates entries at issue, collects writebacks from ALU and LSB, and retires the head entry in program order.
- Drives the commit-side interface of the CDB: commit_flag/value/rename/dest, commit_is_branch, commit_is_jalr, jalr_next_pc and cdb_flush.
- Detects branch mispredicts at commit, then flushes the machine and redirects fetch.

Parameters:
- RENAME_W, 4, tag width; ROB index equals rename tag.
- DEPTH, 16, entry count; must equal 2**RENAME_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; when low, all state holds
- issue_valid  in  1  allocate entry at tail
- issue_type  in  2  0=normal, 1=branch, 2=jalr, 3=reserved (treated as normal)
- issue_dest  in  5  architectural rd
- issue_pc  in  32  instruction PC
- issue_pred_jump  in  1  predictor's taken guess (branch only)
- issue_alt_pc  in  32  PC to fetch if the prediction is wrong
- issue_rename  out  4  tag granted (current tail)
- rob_full  out  1  count==DEPTH
- alu_wb_valid, lsb_wb_valid  in  1 each  writeback strobes
- alu_wb_rename, lsb_wb_rename  in  4 each  writeback tags
- alu_wb_value, lsb_wb_value  in  32 each  results; branch result in bit 0 = taken; jalr result = target
- query_rename1, query_rename2  in  4 each  RS operand lookup tags
- query_ready1, query_ready2  out  1 each  entry holds a value (combinational)
- query_value1, query_value2  out  32 each  entry value (combinational)
- commit_flag  out  1  registered, one-cycle pulse per retire
- commit_value  out  32
- commit_rename  out  4
- commit_dest  out  5
- commit_is_branch  out  1
- commit_is_jalr  out  1
- jalr_next_pc  out  32  committed pc+4
- cdb_flush  out  1  one-cycle flush pulse
- flush_pc  out  32  redirect address, valid with cdb_flush

Behaviour:
- Storage:
  - Circular buffer with head and tail (RENAME_W bits, natural wrap at DEPTH-1→0) and a count of RENAME_W+1 bits.
  - Each entry holds busy, ready, type, dest, pc, pred, alt_pc, value.
- Reset: head=tail=count=0, every busy=0, all registered outputs 0.
- Issue:
  - When issue_valid && !rob_full, write the entry at tail with busy=1, ready=0, then tail++.
  - rob_full is computed from the current count only; a commit in the same cycle does not free a slot for issue.
  - issue_valid while full is ignored. The issuer must not assert it.
- Writeback:
  - Each strobe sets value and ready=1 in the tagged entry, taking effect next cycle (no bypass to commit).
  - ALU and LSB writing the same tag in one cycle is illegal; if it happens, LSB wins.
  - Writeback to a non-busy entry is ignored.
- Query: ready = busy && ready bit, read combinationally from state (no writeback bypass).
- Commit:
  - Condition: rdy && head busy && head ready && no flush pending.
  - Next cycle: commit_flag=1; the other commit outputs come from the head entry; jalr_next_pc = pc+4 (mod 2^32).
  - Entry freed, head++, count--.
  - At most one commit per cycle. commit_flag is 0 in any non-commit cycle; the other commit outputs hold their last values.
- Mispredict:
  - A committing branch with value[0] != pred sets flush_pending.
  - In the following cycle: cdb_flush=1, flush_pc=alt_pc; head=tail=count=0 and all busy cleared; issue and writebacks that cycle are dropped.
  - A correctly predicted branch does not flush.
  - jalr never flushes here; fetch redirects on jalr_commit from the CDB.
- Simultaneous issue and commit: count unchanged, head and tail both advance.
- Reset mid-flush: reset wins and cdb_flush is 0 next cycle.

Optional Feature:
- Macro ROB_COMMIT_COUNT_EN.
- Defined: adds output port commit_count [31:0]. It resets to 0, increments on every commit_flag cycle, wraps at 2^32, and is unaffected by flush.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package rob_pkg:
  - Type encodings ROB_NORMAL=0, ROB_BRANCH=1, ROB_JALR=2.
  - RENAME_W and DEPTH defaults.
  - Entry struct typedef.
- No sub-module: pointer, count and entry logic share state tightly, so a single module is used.

Test Plan:
- Reset, then issue 3 normal ops (dest 1,2,3). Write back tag 2 (0x22), then tag 0 (0x11), then tag 1. Expected commits in order: tags 0,1,2 with values 0x11, (tag 1 value), 0x22. Tag 2 never retires before tag 1.
- Issue 16 ops: rob_full=1 and a 17th issue_valid is ignored. Write back tag 0, then issue in the commit cycle: still rejected. Accepted the next cycle with issue_rename=0 (wrap).
- Branch with pred=1 written back with value 0 commits (commit_is_branch=1, commit_value[0]=0). Next cycle cdb_flush=1, flush_pc=alt_pc 0x1040. Then rob_full=0, count 0, and younger entries never commit.
- jalr at pc 0x100, dest 1, writeback 0x200: commit_is_jalr=1, commit_value=0x200, jalr_next_pc=0x104, no flush.
- rdy=0 with a ready head: no commit_flag until rdy=1. Query on a ready tag returns ready=1 and the value; query on a pending tag returns ready=0.
- With ROB_COMMIT_COUNT_EN defined, 5 commits then a flush: commit_count=5.
